obi_data_responder: RTL and testbench
=====================================

OBI_DATA_RESPONDER -- requirements
Module: obi_data_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning number of 32-bit words of internal storage (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 1, meaning cycles from acceptance edge to rvalid cycle (1..4).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, meaning response-queue depth (1..4).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_req_i  input  1  master request.
REQ-007 SHALL have port data_gnt_o  output  1  grant; acceptance = req & gnt in same cycle.
REQ-008 SHALL have port data_addr_i  input  32  byte address.
REQ-009 SHALL have port data_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port data_be_i  input  4  byte enables, bit n = byte lane n.
REQ-011 SHALL have port data_wdata_i  input  32  write data.
REQ-012 SHALL have port data_rvalid_o  output  1  response valid, single cycle per response.
REQ-013 SHALL have port data_rdata_o  output  32  read data, valid only with rvalid.
REQ-014 SHALL have port data_err_o  output  1  error flag, valid only with rvalid.
REQ-015 SHALL have port gnt_stall_i  input  1  test hook; 1 forces data_gnt_o low.

Function
REQ-016 SHALL drive data_gnt_o = data_req_i & ~gnt_stall_i & (count < MAX_OUTSTANDING | data_rvalid_o), combinationally; count = accepted-but-unresponded transactions.
REQ-017 SHALL hold data_gnt_o low whenever data_req_i is low.
REQ-018 SHALL decode word index = data_addr_i[log2(MEM_WORDS)+1:2]; data_addr_i[1:0] ignored.
REQ-019 SHALL flag an access out-of-range when data_addr_i >= 4*MEM_WORDS.
REQ-020 SHALL, on accepted in-range write, update memory at the acceptance edge, only byte lanes with data_be_i set; be = 4'h0 writes nothing and is not an error.
REQ-021 SHALL, on accepted in-range read, capture the memory word at the acceptance edge (value before any write accepted at the same edge; only one transaction accepted per edge).
REQ-022 SHALL, on any out-of-range access, not modify memory, return rdata 0 and err 1.
REQ-023 SHALL return rdata 0 for writes; err 0 for in-range accesses.
REQ-024 SHALL push each accepted transaction into an in-order response queue (depth MAX_OUTSTANDING) with a per-entry age counter reset to 1 at acceptance and incremented each edge, saturating at LATENCY.
REQ-025 SHALL assert data_rvalid_o for exactly one cycle when queue head age equals LATENCY, i.e. LATENCY cycles after the acceptance edge, and pop the head at the end of that cycle.
REQ-026 SHALL deliver responses strictly in acceptance order; no two rvalids in one cycle.
REQ-027 SHALL, on simultaneous push and pop in one cycle, leave count unchanged.
REQ-028 SHALL sustain one transaction per cycle when MAX_OUTSTANDING >= LATENCY and gnt_stall_i = 0.
REQ-029 SHALL never overflow the queue; a full queue without a same-cycle pop deasserts gnt.
REQ-030 SHALL drive data_rdata_o and data_err_o to 0 in cycles where data_rvalid_o is 0.
REQ-031 SHALL keep a request that is not granted fully unaffected (no memory write, no queue entry); the master may hold or change it.

Reset
REQ-032 SHALL, while n_reset low, force data_gnt_o 0, data_rvalid_o 0, data_rdata_o 0, data_err_o 0, count 0, queue empty.
REQ-033 SHALL discard all pending responses when reset asserts mid-operation; none appear after release.
REQ-034 SHALL leave memory contents unaffected by reset (undefined at power-up).
REQ-035 SHALL accept a request in the first cycle after reset release.

Verification
REQ-036 Default params: write addr 0x10, wdata 0xDEADBEEF, be 4'hF; then read 0x10 -> write rvalid 1 cycle after grant with rdata 0; read rvalid 1 cycle after grant with rdata 0xDEADBEEF, err 0.
REQ-037 Byte enables: after 0xDEADBEEF at 0x10, write 0x11223344 with be 4'b0101; read 0x13 -> rdata 0xDE22BE44.
REQ-038 LATENCY=3, MAX_OUTSTANDING=2: req held high for 4 reads -> gnt pattern 1,1,0,1,1 (3rd grant waits until first rvalid cycle); rvalids in order, each exactly 3 cycles after its grant.
REQ-039 Out-of-range: read addr 0x400 (MEM_WORDS=256) -> rvalid with err 1, rdata 0; write 0x400 changes no memory word.
REQ-040 gnt_stall_i high 5 cycles with req high -> gnt 0 throughout, no rvalid; stall drop -> gnt 1 same cycle.
REQ-041 Reset asserted one cycle after grant with LATENCY=2 -> no rvalid during or after reset; next request granted first cycle after release.

Source files
------------

// File: rtl/obi_data_responder.sv
// obi_data_responder
//   OBI data-side slave with internal word memory and a fixed-latency,
//   in-order response queue.
//
//   Parameters
//     MEM_WORDS       : number of 32-bit words of storage (power of two, 16..4096)
//     LATENCY         : cycles from acceptance edge to the rvalid cycle (1..4)
//     MAX_OUTSTANDING : response-queue depth (1..4)
//
//   Ports
//     clk            : clock, rising edge
//     n_reset        : asynchronous active-low reset
//     data_req_i     : master request
//     data_gnt_o     : grant (combinational); acceptance = req & gnt
//     data_addr_i    : byte address
//     data_we_i      : 1 = write, 0 = read
//     data_be_i      : byte enables, bit n = byte lane n
//     data_wdata_i   : write data
//     data_rvalid_o  : single-cycle response valid
//     data_rdata_o   : read data, zero when rvalid is low
//     data_err_o     : error flag (out-of-range access), zero when rvalid is low
//     gnt_stall_i    : test hook, forces grant low
module obi_data_responder #(
    parameter int MEM_WORDS       = 256,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        gnt_stall_i
);

    localparam int         AW   = $clog2(MEM_WORDS);
    localparam logic [2:0] LAT  = 3'(LATENCY);
    localparam logic [2:0] MAXO = 3'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  age;
    } entry_t;

    logic [31:0]    mem_r [MEM_WORDS];
    entry_t         queue_r [MAX_OUTSTANDING];
    entry_t         queue_next_s [MAX_OUTSTANDING];
    logic [2:0]     count_r;
    logic [2:0]     count_next_s;
    logic [2:0]     push_pos_s;
    entry_t         slot_s;
    entry_t         new_entry_s;
    logic [AW-1:0]  word_idx_s;
    logic           out_of_range_s;
    logic           accept_s;
    logic           pop_s;

    assign word_idx_s     = data_addr_i[AW+1:2];
    // Any set bit above the storage window means address >= 4*MEM_WORDS.
    assign out_of_range_s = |data_addr_i[31:AW+2];

    // The head is always the oldest entry, so only it can have reached LATENCY first.
    assign pop_s = (count_r != 3'd0) && (queue_r[0].age == LAT);

    // A same-cycle pop frees a slot, which keeps full throughput when the queue is full.
    assign data_gnt_o = n_reset & data_req_i & ~gnt_stall_i & ((count_r < MAXO) | pop_s);
    assign accept_s   = data_gnt_o;

    assign data_rvalid_o = pop_s;
    assign data_rdata_o  = pop_s ? queue_r[0].rdata : 32'd0;
    assign data_err_o    = pop_s ? queue_r[0].err   : 1'b0;

    // Response payload for the transaction being accepted this cycle.
    always_comb begin
        new_entry_s.age   = 3'd1;
        new_entry_s.rdata = 32'd0;
        new_entry_s.err   = 1'b0;
        if (out_of_range_s) begin
            new_entry_s.err = 1'b1;
        end else if (data_we_i) begin
            new_entry_s.rdata = 32'd0;
        end else begin
            new_entry_s.rdata = mem_r[word_idx_s];
        end
    end

    // Next queue contents: shift on pop, age every entry, append on accept.
    always_comb begin
        slot_s     = queue_r[0];
        push_pos_s = pop_s ? (count_r - 3'd1) : count_r;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (pop_s) begin
                slot_s = queue_r[(i + 1) % MAX_OUTSTANDING];
            end else begin
                slot_s = queue_r[i];
            end
            if (slot_s.age < LAT) begin
                slot_s.age = slot_s.age + 3'd1;
            end else begin
                slot_s.age = LAT;
            end
            if (accept_s && (3'(i) == push_pos_s)) begin
                queue_next_s[i] = new_entry_s;
            end else begin
                queue_next_s[i] = slot_s;
            end
        end
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_r + 3'd1;
            2'b01:   count_next_s = count_r - 3'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Queue and occupancy registers; reset discards every pending response.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_r <= 3'd0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                queue_r[i] <= '0;
            end
        end else begin
            count_r <= count_next_s;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                queue_r[i] <= queue_next_s[i];
            end
        end
    end

    // Storage is not reset so its contents survive n_reset.
    always_ff @(posedge clk) begin
        if (accept_s && data_we_i && !out_of_range_s) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_obi_data_responder.sv
// tb_obi_data_responder
//   Three instances share one stimulus bus: defaults (LATENCY 1), LATENCY 3 and
//   LATENCY 2 (both MAX_OUTSTANDING 2). Each phase selects the instance whose
//   outputs are compared. Table rows hold inputs, expected grant and expected
//   response; accepted rows push their response with a due cycle into a
//   scoreboard queue that is checked every cycle.
module tb_obi_data_responder;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall = 1'b0;

    logic [2:0]  g, rv, er;
    logic [31:0] rd [3];
    int          sel = 0;
    logic        sg, srv, serr;
    logic [31:0] srd;

    always #5 clk = ~clk;

    obi_data_responder u_l1 (
        .clk(clk), .n_reset(n_reset), .data_req_i(req), .data_gnt_o(g[0]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv[0]), .data_rdata_o(rd[0]), .data_err_o(er[0]), .gnt_stall_i(stall));

    obi_data_responder #(.MEM_WORDS(256), .LATENCY(3), .MAX_OUTSTANDING(2)) u_l3 (
        .clk(clk), .n_reset(n_reset), .data_req_i(req), .data_gnt_o(g[1]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv[1]), .data_rdata_o(rd[1]), .data_err_o(er[1]), .gnt_stall_i(stall));

    obi_data_responder #(.MEM_WORDS(256), .LATENCY(2), .MAX_OUTSTANDING(2)) u_l2 (
        .clk(clk), .n_reset(n_reset), .data_req_i(req), .data_gnt_o(g[2]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv[2]), .data_rdata_o(rd[2]), .data_err_o(er[2]), .gnt_stall_i(stall));

    always_comb begin
        case (sel)
            1:       begin sg = g[1]; srv = rv[1]; srd = rd[1]; serr = er[1]; end
            2:       begin sg = g[2]; srv = rv[2]; srd = rd[2]; serr = er[2]; end
            default: begin sg = g[0]; srv = rv[0]; srd = rd[0]; serr = er[0]; end
        endcase
    end

    typedef struct {
        int          sel;
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          stall;
        bit          gnt;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          due;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int s, input bit rq, input bit w, input logic [31:0] a,
                                input logic [3:0] b, input logic [31:0] wd, input bit st,
                                input bit gn, input logic [31:0] r, input bit e);
        vec_t v;
        v.sel = s; v.req = rq; v.we = w; v.addr = a; v.be = b; v.wdata = wd;
        v.stall = st; v.gnt = gn; v.rdata = r; v.err = e;
        return v;
    endfunction

    function automatic vec_t wr(input int s, input logic [31:0] a, input logic [3:0] b,
                                input logic [31:0] wd, input bit gn, input bit e);
        return mk(s, 1'b1, 1'b1, a, b, wd, 1'b0, gn, 32'd0, e);
    endfunction

    function automatic vec_t rdv(input int s, input logic [31:0] a, input bit gn,
                                 input logic [31:0] r, input bit e);
        return mk(s, 1'b1, 1'b0, a, 4'hF, 32'd0, 1'b0, gn, r, e);
    endfunction

    function automatic vec_t idle(input int s);
        return mk(s, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d, sel %0d)", name, act, exp, cyc, sel);
        end
    endtask

    // Compare this cycle's response against the scoreboard head.
    task automatic check_resp();
        bit   exp_rv;
        exp_t e;
        exp_rv = (sb.size() != 0) && (sb[0].due == cyc);
        chk("rvalid", {31'd0, srv}, {31'd0, exp_rv});
        if (exp_rv) begin
            e = sb.pop_front();
            chk("rdata", srd, e.rdata);
            chk("err", {31'd0, serr}, {31'd0, e.err});
        end else begin
            chk("rdata_idle", srd, 32'd0);
            chk("err_idle", {31'd0, serr}, 32'd0);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        int   lat;
        lat   = (v.sel == 1) ? 3 : ((v.sel == 2) ? 2 : 1);
        sel   = v.sel;
        req   = v.req; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata; stall = v.stall;
        @(negedge clk);
        check_resp();
        chk("gnt", {31'd0, sg}, {31'd0, v.gnt});
        if (v.gnt) begin
            e.rdata = v.rdata; e.err = v.err; e.due = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic hold_reset(input int n);
        n_reset = 1'b0;
        sb.delete();
        req = 1'b1; we = 1'b0; addr = 32'd0; be = 4'hF; stall = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_gnt", {31'd0, sg}, 32'd0);
            chk("rst_rvalid", {31'd0, srv}, 32'd0);
            chk("rst_rdata", srd, 32'd0);
            chk("rst_err", {31'd0, serr}, 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        n_reset = 1'b1;
    endtask

    initial begin
        // Default instance: basic write/read, byte lanes, range edges, stall.
        tbl.push_back(wr(0, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b1, 1'b0));
        tbl.push_back(wr(0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0));
        tbl.push_back(rdv(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0));
        tbl.push_back(wr(0, 32'h0000_0010, 4'b0101, 32'h1122_3344, 1'b1, 1'b0));
        tbl.push_back(rdv(0, 32'h0000_0013, 1'b1, 32'hDE22_BE44, 1'b0));
        tbl.push_back(wr(0, 32'h0000_03FC, 4'hF, 32'h1234_5678, 1'b1, 1'b0));
        tbl.push_back(rdv(0, 32'h0000_03FE, 1'b1, 32'h1234_5678, 1'b0));
        tbl.push_back(rdv(0, 32'h0000_0400, 1'b1, 32'h0000_0000, 1'b1));
        tbl.push_back(wr(0, 32'h0000_0400, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1));
        tbl.push_back(rdv(0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b1));
        tbl.push_back(rdv(0, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, 1'b0));
        tbl.push_back(wr(0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b1, 1'b0));
        tbl.push_back(rdv(0, 32'h0000_0010, 1'b1, 32'hDE22_BE44, 1'b0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 1'b0));
        tbl.push_back(rdv(0, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, 1'b0));
        tbl.push_back(mk(0, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'd0, 1'b0));
        for (int i = 0; i < 4; i++) tbl.push_back(idle(0));
        // LATENCY 3 / depth 2: grant waits for the first rvalid when full.
        tbl.push_back(wr(1, 32'h20, 4'hF, 32'h1111_1111, 1'b1, 1'b0));
        tbl.push_back(wr(1, 32'h24, 4'hF, 32'h2222_2222, 1'b1, 1'b0));
        tbl.push_back(wr(1, 32'h28, 4'hF, 32'h3333_3333, 1'b0, 1'b0));
        tbl.push_back(wr(1, 32'h28, 4'hF, 32'h3333_3333, 1'b1, 1'b0));
        tbl.push_back(wr(1, 32'h2C, 4'hF, 32'h4444_4444, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) tbl.push_back(idle(1));
        tbl.push_back(rdv(1, 32'h20, 1'b1, 32'h1111_1111, 1'b0));
        tbl.push_back(rdv(1, 32'h24, 1'b1, 32'h2222_2222, 1'b0));
        tbl.push_back(rdv(1, 32'h28, 1'b0, 32'h0, 1'b0));
        tbl.push_back(rdv(1, 32'h28, 1'b1, 32'h3333_3333, 1'b0));
        tbl.push_back(rdv(1, 32'h2C, 1'b1, 32'h4444_4444, 1'b0));
        for (int i = 0; i < 3; i++) tbl.push_back(idle(1));

        hold_reset(3);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // LATENCY 2: reset one cycle after a grant discards the pending read.
        apply(wr(2, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0));
        apply(idle(2));
        apply(idle(2));
        apply(rdv(2, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0));
        hold_reset(3);
        apply(rdv(2, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0));
        for (int i = 0; i < 3; i++) apply(idle(2));

        chk("drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
